rx_sample_ring_sweeper: RTL
===========================

Name: rx_sample_ring_sweeper

Overview:
Parametrised circular sample store for the receive chain. It holds the most recent DEPTH samples of DATA_WIDTH bits. On each new_sample_trig it replays the stored samples as a framed stream, oldest to newest, with valid/first/last markers. It adds fill tracking for a partially filled buffer, a sweep state machine, enable gating and overrun detection, and feeds the correlator/filter stages downstream of the filtered-sample path.

Parameters:
DATA_WIDTH, 16, sample width in bits (signed)
DEPTH, 510, number of stored samples; legal range 2 to 2^ADDR_WIDTH
ADDR_WIDTH, 9, pointer width; must satisfy DEPTH <= 2^ADDR_WIDTH
CNT_WIDTH, 10, fill and sweep counter width; must hold the value DEPTH

Ports:
crx_clk  in  1  clock; all logic on rising edge
rrx_rst  in  1  reset, synchronous, active-high
erx_en  in  1  global enable; low freezes all state
new_sample_trig  in  1  one-cycle pulse requesting a sweep
wr_en_RAM  in  1  store data_in_RAM this cycle
data_in_RAM  in  DATA_WIDTH  signed sample to store
data_out_RAM  out  DATA_WIDTH  signed replayed sample
data_out_valid  out  1  data_out_RAM is valid this cycle
data_out_first  out  1  marks the oldest sample of the sweep
data_out_last  out  1  marks the newest sample of the sweep; doubles as sweep-done
sweep_busy  out  1  high while a sweep is in progress
fill_count  out  CNT_WIDTH  number of valid stored samples, saturating at DEPTH
overrun  out  1  sticky flag: a trigger arrived while a sweep was busy

Behaviour:
- Memory: simple dual-port, inferred, DEPTH x DATA_WIDTH.
  - Registered read, 1-cycle latency.
  - Read-first on a same-address collision: the read returns the old data.
- Reset: wr_ptr=0, rd_ptr=0, fill_count=0, FSM=IDLE, overrun=0. All data_out_* outputs and sweep_busy are 0. Memory contents are not cleared.
- erx_en=0: no write, no pointer/counter/FSM change, data_out_valid/first/last forced 0. The sweep resumes where it stopped once erx_en returns high. The "resumes" rule below always assumes erx_en is high.
- Write (erx_en & wr_en_RAM): mem[wr_ptr] <= data_in_RAM.
  - wr_ptr wraps from DEPTH-1 to 0.
  - fill_count increments and saturates at DEPTH.
- FSM states: IDLE, SWEEP, FLUSH.
  - IDLE + trig, fill_count after any same-cycle write = N:
    - If N=0: the trigger is ignored and no output is produced.
    - Else: snapshot the sweep length N. Start address = (N==DEPTH) ? next wr_ptr : 0. Go to SWEEP and set sweep_busy=1.
    - A same-cycle write is included in the sweep as its newest sample.
  - SWEEP: one read address per cycle, with wrap at DEPTH-1. After N addresses have been issued, go to FLUSH.
  - FLUSH: the final read data is output; return to IDLE. sweep_busy falls in the cycle after data_out_last.
- Output timing: trigger in cycle T gives data_out_valid in cycles T+2 .. T+N+1, with no gaps.
  - data_out_first is asserted in cycle T+2; data_out_last in cycle T+N+1.
  - For N=1, first and last assert in the same cycle.
- Trigger while sweep_busy: the trigger is ignored, overrun is set to 1 and stays 1 until reset. The current sweep continues unchanged.
- Writes during a sweep are allowed, and the pointer advances normally.
  - With N=DEPTH, a write lands on a slot that has already been read, so the sweep shows snapshot contents.
  - With N<DEPTH, the newest slot written during the sweep is outside the snapshot length and is not output.
- data_out_RAM holds its last value when valid is low. Downstream logic must use only the valid-qualified values.
- Reset asserted mid-sweep: the sweep aborts immediately and no further valid cycles are produced.

Test Plan:
1. DEPTH=8. Reset, write 3 samples (10, 20, 30), trigger -> valid for 3 cycles starting at T+2 with data 10, 20, 30; first on 10, last on 30; fill_count=3.
2. DEPTH=8. Write 11 samples with values 1..11, trigger -> 8 valid cycles with data 4..11; first on 4, last on 11; fill_count=8; wr_ptr wrapped to 3.
3. Trigger immediately after reset (fill_count=0) -> no valid, sweep_busy stays 0, overrun=0.
4. Trigger and write of value 99 in the same cycle with 7 prior samples (DEPTH=8) -> 8-sample sweep; 99 is the last sample and carries data_out_last.
5. Second trigger in cycle T+3 of a full sweep -> the sweep completes 8 samples unchanged, overrun=1 and remains 1. A later trigger issued after sweep_busy falls runs normally.
6. erx_en low for 3 cycles in mid-sweep -> valid gap of 3 cycles, sequence continues contiguously with no lost or repeated samples. Separately, rrx_rst mid-sweep -> all outputs 0 in the next cycle.

Source files
------------

// File: rtl/rx_sample_ring_sweeper.sv
// Circular sample store for the receive chain. Keeps the latest DEPTH samples
// and, on request, replays them oldest-to-newest as a framed valid/first/last
// stream with fill tracking, enable gating and sticky overrun detection.
module rx_sample_ring_sweeper #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 510,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned CNT_WIDTH  = 10
) (
    input  logic                         crx_clk,
    input  logic                         rrx_rst,
    input  logic                         erx_en,
    input  logic                         new_sample_trig,
    input  logic                         wr_en_RAM,
    input  logic signed [DATA_WIDTH-1:0] data_in_RAM,
    output logic signed [DATA_WIDTH-1:0] data_out_RAM,
    output logic                         data_out_valid,
    output logic                         data_out_first,
    output logic                         data_out_last,
    output logic                         sweep_busy,
    output logic [CNT_WIDTH-1:0]         fill_count,
    output logic                         overrun
);

    localparam logic [CNT_WIDTH-1:0]  LP_DEPTH     = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  LP_ONE       = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StFlush
    } state_e;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_fill;
    logic [CNT_WIDTH-1:0]  r_remain;
    logic                  r_first_pend;
    logic                  r_busy;
    logic                  r_overrun;
    logic                  r_valid;
    logic                  r_first;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_dout;

    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
    logic [CNT_WIDTH-1:0]  w_fill_nxt;
    logic [ADDR_WIDTH-1:0] w_start_addr;

    // Next-state helpers for pointers and fill; fill_nxt includes a same-cycle write.
    always_comb begin
        w_wr         = erx_en & wr_en_RAM;
        w_wr_ptr_nxt = (r_wr_ptr == LP_LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_nxt = (r_rd_ptr == LP_LAST_ADDR) ? '0 : r_rd_ptr + 1'b1;
        w_fill_nxt   = (w_wr && (r_fill != LP_DEPTH)) ? r_fill + 1'b1 : r_fill;
        // A full ring starts at the oldest slot, i.e. where the next write would go.
        if (w_fill_nxt == LP_DEPTH) begin
            w_start_addr = w_wr ? w_wr_ptr_nxt : r_wr_ptr;
        end else begin
            w_start_addr = '0;
        end
    end

    // Sample storage write port; left unreset so it maps onto block RAM.
    always_ff @(posedge crx_clk) begin
        if (!rrx_rst && w_wr) begin
            r_mem[r_wr_ptr] <= data_in_RAM;
        end
    end

    // Registered read port; read-first, so a colliding write is not seen.
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            r_dout <= '0;
        end else if (erx_en && (r_state == StSweep)) begin
            r_dout <= r_mem[r_rd_ptr];
        end
    end

    // Pointer/fill tracking and the sweep FSM with its registered stream markers.
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            r_state      <= StIdle;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill       <= '0;
            r_remain     <= '0;
            r_first_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
            r_valid      <= 1'b0;
            r_first      <= 1'b0;
            r_last       <= 1'b0;
        end else if (erx_en) begin
            if (w_wr) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            r_fill  <= w_fill_nxt;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (new_sample_trig && (w_fill_nxt != '0)) begin
                        r_rd_ptr     <= w_start_addr;
                        r_remain     <= w_fill_nxt;
                        r_first_pend <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= StSweep;
                    end
                end
                StSweep: begin
                    // Markers travel alongside the read so they line up with r_dout.
                    r_valid      <= 1'b1;
                    r_first      <= r_first_pend;
                    r_first_pend <= 1'b0;
                    r_last       <= (r_remain == LP_ONE);
                    r_rd_ptr     <= w_rd_ptr_nxt;
                    r_remain     <= r_remain - 1'b1;
                    if (r_remain == LP_ONE) begin
                        r_state <= StFlush;
                    end
                    if (new_sample_trig) begin
                        r_overrun <= 1'b1;
                    end
                end
                StFlush: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                    if (new_sample_trig) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Stream markers are masked while disabled; the frozen state replays on re-enable.
    always_comb begin
        data_out_RAM   = r_dout;
        data_out_valid = r_valid & erx_en;
        data_out_first = r_first & erx_en;
        data_out_last  = r_last & erx_en;
        sweep_busy     = r_busy;
        fill_count     = r_fill;
        overrun        = r_overrun;
    end

endmodule
